// File: rtl/lut_eval_pkg.sv
// Shared types and helpers for the programmable truth-table evaluator.
// The FSM state enum, the table-width function and the row-to-bit mapping
// live here so the top level and the loader agree on them.
package lut_eval_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SWEEP = 2'd2
  } lut_state_e;

  // Widest table supported (N_IN = 6).
  localparam int MAX_TT_W = 64;

  // Number of truth-table entries for n inputs.
  function automatic int tt_width(input int n);
    return 1 << n;
  endfunction

  // Row 0 selects the table MSB; row tt_w-1 selects bit 0.
  function automatic logic row_bit(input logic [MAX_TT_W-1:0] tt,
                                   input int tt_w,
                                   input int r);
    logic [5:0] idx;
    idx = 6'(tt_w - 1 - r);
    return tt[idx];
  endfunction

endpackage

// File: rtl/lut_eval_loader.sv
// Serial table loader: shifts configuration bits MSB-first into a shadow
// register, counts them, and raises a commit strobe on the final bit. The
// completed table (shadow plus the bit arriving this cycle) is presented on
// commit_tt so the parent can capture it on the same edge.
module lut_eval_loader #(
  parameter int  N_IN = 3,
  localparam int TT_W = 1 << N_IN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            shift,
  input  logic            bit_in,
  output logic            commit,
  output logic [TT_W-1:0] commit_tt
);

  logic [TT_W-2:0] shadow;
  logic [N_IN:0]   bit_cnt;

  assign commit    = shift && (bit_cnt == (N_IN+1)'(TT_W - 1));
  assign commit_tt = {shadow, bit_in};

  // Shadow shift register and bit counter; start or commit clears both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= '0;
      bit_cnt <= '0;
    end else if (start || commit) begin
      shadow  <= '0;
      bit_cnt <= '0;
    end else if (shift) begin
      shadow  <= commit_tt[TT_W-2:0];
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/lut_eval_seq.sv
// Programmable N-input truth-table evaluator.
// Holds the control FSM, the committed table, the one-deep output register
// and (optionally) the self-test sweep counter.
// Optional feature: define LUT_EVAL_SWEEP_EN to add the sweep_start /
// sweep_done / sweep_count ports and the SWEEP state.
module lut_eval_seq
  import lut_eval_pkg::*;
#(
  parameter int                          N_IN    = 3,
  parameter logic [tt_width(N_IN)-1:0]   TT_INIT = 8'hE8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_start,
  input  logic            cfg_valid,
  input  logic            cfg_bit,
  output logic            cfg_busy,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N_IN-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_bit,
  output logic [N_IN-1:0] out_row
`ifdef LUT_EVAL_SWEEP_EN
  ,
  input  logic            sweep_start,
  output logic            sweep_done,
  output logic [N_IN:0]   sweep_count
`endif
);

  localparam int TT_W = tt_width(N_IN);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_LOAD  = LOAD;
`ifdef LUT_EVAL_SWEEP_EN
  localparam logic [1:0] S_SWEEP = SWEEP;
`endif

  logic [1:0]      state;
  logic [TT_W-1:0] tt;
  logic            ld_start;
  logic            ld_shift;
  logic            commit;
  logic [TT_W-1:0] commit_tt;
  logic            accept;
  logic            vld_p1;
  logic            bit_p1;
  logic [N_IN-1:0] row_p1;

`ifdef LUT_EVAL_SWEEP_EN
  logic [N_IN-1:0] sweep_row;
  logic [N_IN:0]   sweep_acc;
  logic            sweep_bit;

  assign sweep_bit = row_bit(MAX_TT_W'(tt), TT_W, int'(sweep_row));
  // Sweep blocks new requests; a result already held stays valid.
  assign in_ready  = (!vld_p1 || out_ready) && (state != S_SWEEP);
  assign ld_start  = cfg_start && (state != S_SWEEP);
`else
  assign in_ready  = !vld_p1 || out_ready;
  assign ld_start  = cfg_start;
`endif

  // A start pulse in the same cycle as a bit restarts the load and drops the bit.
  assign ld_shift  = cfg_valid && (state == S_LOAD) && !cfg_start;
  assign cfg_busy  = (state == S_LOAD);
  assign accept    = in_valid && in_ready;
  assign out_valid = vld_p1;
  assign out_bit   = bit_p1;
  assign out_row   = row_p1;

  lut_eval_loader #(
    .N_IN (N_IN)
  ) u_loader (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (ld_start),
    .shift     (ld_shift),
    .bit_in    (cfg_bit),
    .commit    (commit),
    .commit_tt (commit_tt)
  );

  // Control FSM: a pending load start always takes priority over a sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (cfg_start) begin
            state <= S_LOAD;
          end
`ifdef LUT_EVAL_SWEEP_EN
          else if (sweep_start) begin
            state <= S_SWEEP;
          end
`endif
        end
        S_LOAD: begin
          if (!cfg_start && commit) begin
            state <= S_IDLE;
          end
        end
`ifdef LUT_EVAL_SWEEP_EN
        S_SWEEP: begin
          if (&sweep_row) begin
            state <= S_IDLE;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  // Committed table: only a complete load replaces it, on the final-bit edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tt <= TT_INIT;
    end else if (commit) begin
      tt <= commit_tt;
    end
  end

  // ---- stage p1: one-deep output register, holds while stalled ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      bit_p1 <= 1'b0;
      row_p1 <= '0;
    end else if (accept) begin
      vld_p1 <= 1'b1;
      bit_p1 <= row_bit(MAX_TT_W'(tt), TT_W, int'(in_data));
      row_p1 <= in_data;
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

`ifdef LUT_EVAL_SWEEP_EN
  // Self-test sweep: walk every row, count ones, publish with a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_row   <= '0;
      sweep_acc   <= '0;
      sweep_count <= '0;
      sweep_done  <= 1'b0;
    end else begin
      sweep_done <= 1'b0;
      if ((state == S_IDLE) && !cfg_start && sweep_start) begin
        sweep_row <= '0;
        sweep_acc <= '0;
      end else if (state == S_SWEEP) begin
        if (&sweep_row) begin
          sweep_count <= sweep_acc + {{N_IN{1'b0}}, sweep_bit};
          sweep_done  <= 1'b1;
        end else begin
          sweep_row <= sweep_row + 1'b1;
          sweep_acc <= sweep_acc + {{N_IN{1'b0}}, sweep_bit};
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_lut_eval_seq.sv
// Directed bench for lut_eval_seq: a 3-input instance with the default
// table and a 5-input instance with a single-minterm table.
module tb_lut_eval_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       c_start, c_valid, c_bit, busy;
  logic       iv, ir, ov, ordy, ob;
  logic [2:0] id, orow;

  logic       c_start5, c_valid5, c_bit5, busy5;
  logic       iv5, ir5, ov5, ordy5, ob5;
  logic [4:0] id5, orow5;

`ifdef LUT_EVAL_SWEEP_EN
  logic       sw_start, sw_done;
  logic [3:0] sw_count;
  logic       sw_start5, sw_done5;
  logic [5:0] sw_count5;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [2:0] row;
    logic       exp;
  } vec_t;

  vec_t vecs[24];

  always #5 clk = ~clk;

  lut_eval_seq #(.N_IN(3), .TT_INIT(8'hE8)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .cfg_start(c_start), .cfg_valid(c_valid), .cfg_bit(c_bit), .cfg_busy(busy),
    .in_valid(iv), .in_ready(ir), .in_data(id),
    .out_valid(ov), .out_ready(ordy), .out_bit(ob), .out_row(orow)
`ifdef LUT_EVAL_SWEEP_EN
    , .sweep_start(sw_start), .sweep_done(sw_done), .sweep_count(sw_count)
`endif
  );

  lut_eval_seq #(.N_IN(5), .TT_INIT(32'h8000_0000)) dut5 (
    .clk(clk), .rst_n(rst_n),
    .cfg_start(c_start5), .cfg_valid(c_valid5), .cfg_bit(c_bit5), .cfg_busy(busy5),
    .in_valid(iv5), .in_ready(ir5), .in_data(id5),
    .out_valid(ov5), .out_ready(ordy5), .out_bit(ob5), .out_row(orow5)
`ifdef LUT_EVAL_SWEEP_EN
    , .sweep_start(sw_start5), .sweep_done(sw_done5), .sweep_count(sw_count5)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Apply table rows lo..hi back to back with out_ready high.
  task automatic run_range(input int lo, input int hi, input string name);
    for (int i = lo; i <= hi; i++) begin
      iv   = 1'b1;
      ordy = 1'b1;
      id   = vecs[i].row;
      step();
      check({name, "_valid"}, 64'(ov), 64'd1);
      check({name, "_bit"}, 64'(ob), 64'(vecs[i].exp));
      check({name, "_row"}, 64'(orow), 64'(vecs[i].row));
    end
    iv = 1'b0;
    step();
  endtask

  // Serial load of an 8-bit table into the 3-input instance, MSB first.
  task automatic load8(input logic [7:0] val);
    c_start = 1'b1;
    step();
    c_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      c_valid = 1'b1;
      c_bit   = val[7-k];
      step();
    end
    c_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  pre;
    logic [7:0]  v96;
    logic [31:0] v5;
    int          n;

    // Row tables: default 0xE8, 0x96, 0x01 (row r reads bit 7-r).
    vecs[0]  = '{3'd0, 1'b1}; vecs[1]  = '{3'd1, 1'b1};
    vecs[2]  = '{3'd2, 1'b1}; vecs[3]  = '{3'd3, 1'b0};
    vecs[4]  = '{3'd4, 1'b1}; vecs[5]  = '{3'd5, 1'b0};
    vecs[6]  = '{3'd6, 1'b0}; vecs[7]  = '{3'd7, 1'b0};
    vecs[8]  = '{3'd0, 1'b1}; vecs[9]  = '{3'd1, 1'b0};
    vecs[10] = '{3'd2, 1'b0}; vecs[11] = '{3'd3, 1'b1};
    vecs[12] = '{3'd4, 1'b0}; vecs[13] = '{3'd5, 1'b1};
    vecs[14] = '{3'd6, 1'b1}; vecs[15] = '{3'd7, 1'b0};
    vecs[16] = '{3'd0, 1'b0}; vecs[17] = '{3'd1, 1'b0};
    vecs[18] = '{3'd2, 1'b0}; vecs[19] = '{3'd3, 1'b0};
    vecs[20] = '{3'd4, 1'b0}; vecs[21] = '{3'd5, 1'b0};
    vecs[22] = '{3'd6, 1'b0}; vecs[23] = '{3'd7, 1'b1};

    rst_n = 1'b0;
    c_start = 0; c_valid = 0; c_bit = 0; iv = 0; id = 0; ordy = 0;
    c_start5 = 0; c_valid5 = 0; c_bit5 = 0; iv5 = 0; id5 = 0; ordy5 = 0;
`ifdef LUT_EVAL_SWEEP_EN
    sw_start = 0; sw_start5 = 0;
`endif
    step();
    step();
    check("rst_out_valid", 64'(ov), 64'd0);
    check("rst_out_bit", 64'(ob), 64'd0);
    check("rst_out_row", 64'(orow), 64'd0);
    check("rst_cfg_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(ir), 64'd1);
    rst_n = 1'b1;
    step();

    // Default table, full throughput.
    run_range(0, 7, "def");

    // Load 0x96 while evaluating; results up to and including the commit edge use 0xE8.
    pre = 8'b1110_1000;
    v96 = 8'h96;
    c_start = 1'b1; iv = 1'b1; ordy = 1'b1; id = 3'd3;
    step();
    c_start = 1'b0;
    check("load_busy_rise", 64'(busy), 64'd1);
    check("load_start_r3", 64'(ob), 64'd0);
    for (int k = 0; k < 8; k++) begin
      c_valid = 1'b1;
      c_bit   = v96[7-k];
      id      = (k == 7) ? 3'd3 : 3'(k);
      step();
      check("load_old_table", 64'(ob), 64'(pre[7-k]));
      check("load_busy", 64'(busy), (k < 7) ? 64'd1 : 64'd0);
    end
    c_valid = 1'b0;
    id = 3'd3;
    step();
    check("load_new_r3", 64'(ob), 64'd1);
    iv = 1'b0;
    step();
    run_range(8, 15, "x96");

    // Backpressure: result held, in_ready low, then one result per cycle.
    iv = 1'b1; ordy = 1'b1; id = 3'd0;
    step();
    check("bp_first_bit", 64'(ob), 64'd1);
    ordy = 1'b0; id = 3'd1;
    #1;
    for (int c = 0; c < 3; c++) begin
      check("bp_in_ready", 64'(ir), 64'd0);
      step();
      check("bp_hold_valid", 64'(ov), 64'd1);
      check("bp_hold_bit", 64'(ob), 64'd1);
      check("bp_hold_row", 64'(orow), 64'd0);
    end
    ordy = 1'b1;
    for (int r = 1; r <= 3; r++) begin
      id = 3'(r);
      step();
      check("bp_release_valid", 64'(ov), 64'd1);
      check("bp_release_row", 64'(orow), 64'(r));
      check("bp_release_bit", 64'(ob), (r == 3) ? 64'd1 : 64'd0);
    end
    iv = 1'b0;
    step();
    check("bp_drain", 64'(ov), 64'd0);

    // Restart: 5 bits of ones, then a fresh load of 0x01.
    c_start = 1'b1;
    step();
    c_start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      c_valid = 1'b1; c_bit = 1'b1;
      step();
    end
    c_valid = 1'b0;
    check("restart_busy_mid", 64'(busy), 64'd1);
    load8(8'h01);
    check("restart_busy_done", 64'(busy), 64'd0);
    run_range(16, 23, "x01");

    // cfg_valid outside a load changes nothing.
    for (int k = 0; k < 8; k++) begin
      c_valid = 1'b1; c_bit = 1'b1;
      step();
    end
    c_valid = 1'b0;
    check("idle_cfg_busy", 64'(busy), 64'd0);
    run_range(16, 17, "idle_cfg");

    // Reset in the middle of a load, with a result held in the output register.
    c_start = 1'b1;
    step();
    c_start = 1'b0;
    iv = 1'b1; id = 3'd7; ordy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      c_valid = 1'b1; c_bit = 1'b0;
      step();
    end
    iv = 1'b0; c_valid = 1'b0;
    check("pre_rst_bit", 64'(ob), 64'd1);
    check("pre_rst_row", 64'(orow), 64'd7);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_valid", 64'(ov), 64'd0);
    check("mid_rst_bit", 64'(ob), 64'd0);
    check("mid_rst_row", 64'(orow), 64'd0);
    step();
    rst_n = 1'b1;
    ordy = 1'b1;
    step();
    run_range(0, 7, "post_rst");

`ifdef LUT_EVAL_SWEEP_EN
    // Sweep on the default table; cfg_start mid-sweep is ignored.
    sw_start = 1'b1;
    step();
    sw_start = 1'b0;
    n = 1;
    check("sw_in_ready", 64'(ir), 64'd0);
    c_start = 1'b1;
    step();
    c_start = 1'b0;
    n++;
    check("sw_cfg_ignored", 64'(busy), 64'd0);
    while (!sw_done && n < 30) begin
      step();
      n++;
    end
    check("sw_latency", 64'(n), 64'd9);
    check("sw_count_e8", 64'(sw_count), 64'd4);
    check("sw_after_busy", 64'(busy), 64'd0);
    check("sw_after_ready", 64'(ir), 64'd1);
    step();
    check("sw_done_pulse", 64'(sw_done), 64'd0);

    load8(8'hFF);
    sw_start = 1'b1;
    step();
    sw_start = 1'b0;
    n = 1;
    while (!sw_done && n < 30) begin
      step();
      n++;
    end
    check("sw_latency_ff", 64'(n), 64'd9);
    check("sw_count_ff", 64'(sw_count), 64'd8);
`endif

    // 5-input instance: single minterm at row 0, then a 32-bit load.
    iv5 = 1'b1; ordy5 = 1'b1;
    id5 = 5'd0;  step(); check("n5_r0", 64'(ob5), 64'd1);
    id5 = 5'd1;  step(); check("n5_r1", 64'(ob5), 64'd0);
    id5 = 5'd31; step(); check("n5_r31", 64'(ob5), 64'd0);
    check("n5_row31", 64'(orow5), 64'd31);
    iv5 = 1'b0;
    v5 = 32'h0000_0001;
    c_start5 = 1'b1;
    step();
    c_start5 = 1'b0;
    for (int k = 0; k < 32; k++) begin
      c_valid5 = 1'b1;
      c_bit5   = v5[31-k];
      step();
      if (k == 30) check("n5_busy_31", 64'(busy5), 64'd1);
    end
    c_valid5 = 1'b0;
    check("n5_busy_32", 64'(busy5), 64'd0);
    iv5 = 1'b1;
    id5 = 5'd31; step(); check("n5_new_r31", 64'(ob5), 64'd1);
    id5 = 5'd0;  step(); check("n5_new_r0", 64'(ob5), 64'd0);
    iv5 = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
